// File: rtl/eval_ode_pkg.sv
// eval_ode_pkg: FSM state encoding and width helpers
// shared by evaluate_ode_mc_fp and its divider.
package eval_ode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TAU,
    DIV,
    UPD
  } ode_state_e;

  function automatic int num_w(input int state_w, input int dt_w);
    return state_w + dt_w + 2;
  endfunction

  function automatic int out_w(input int state_w, input int frac_w);
    return state_w - frac_w;
  endfunction

endpackage

// File: rtl/eval_seq_div.sv
// eval_seq_div: signed restoring divider, one quotient bit per cycle,
// quotient truncated toward zero; done pulses once the result is valid.
module eval_seq_div
  import eval_ode_pkg::*;
#(
  parameter int NUM_W = 22,
  parameter int TAU_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [NUM_W-1:0] num,
  input  logic signed [TAU_W-1:0] den,
  output logic                    busy,
  output logic                    done,
  output logic signed [NUM_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q, quo_d;
  logic [TAU_W:0]   rem_q, rem_d;
  logic [TAU_W-1:0] den_q, den_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_W-1:0] num_abs;
  logic [TAU_W-1:0] den_abs;
  logic [TAU_W:0]   rem_sh;
  logic [TAU_W:0]   rem_nx;
  logic [NUM_W-1:0] quo_sh;

  always_comb begin
    num_abs = num[NUM_W-1] ? -num : num;
    den_abs = den[TAU_W-1] ? -den : den;
    rem_sh  = {rem_q[TAU_W-1:0], quo_q[NUM_W-1]};
    quo_sh  = {quo_q[NUM_W-2:0], 1'b0};
    rem_nx  = rem_sh;
    if (rem_sh >= {1'b0, den_q}) begin
      rem_nx    = rem_sh - {1'b0, den_q};
      quo_sh[0] = 1'b1;
    end
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    neg_d  = neg_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    if (start) begin
      quo_d  = num_abs;
      rem_d  = '0;
      den_d  = den_abs;
      neg_d  = num[NUM_W-1] ^ den[TAU_W-1];
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = quo_sh;
      rem_d = rem_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(NUM_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = neg_q ? -signed'(quo_q) : signed'(quo_q);

endmodule

// File: rtl/evaluate_ode_mc_fp.sv
// evaluate_ode_mc_fp: multi-channel fixed-point ODE stepper, o += (T-o)*dt/tau.
// Define EVAL_SAT_EN to clamp the state update and drive the sticky sat flag.
module evaluate_ode_mc_fp
  import eval_ode_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int IN_W    = 9,
  parameter int STATE_W = 16,
  parameter int FRAC_W  = 9,
  parameter int TAU_W   = 24,
  parameter int K_REF   = -1115,
  parameter int K_REG   = 1131,
  parameter int K_C     = 1529,
  parameter int TARGET  = 105,
  parameter int DT_W    = 4,
  parameter int DT_Q    = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                step,
  input  logic [NCH*IN_W-1:0]                 vref,
  input  logic [NCH*IN_W-1:0]                 vreg,
  output logic [NCH*(STATE_W-FRAC_W)-1:0]     out,
  output logic                                busy,
  output logic                                done,
  output logic                                overrun,
  output logic                                sat
);

  localparam int NUM_W = num_w(STATE_W, DT_W);
  localparam int OUT_W = out_w(STATE_W, FRAC_W);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(NUM_W + 1);

  localparam logic signed [TAU_W-1:0] KREF_S = TAU_W'(K_REF);
  localparam logic signed [TAU_W-1:0] KREG_S = TAU_W'(K_REG);
  localparam logic signed [TAU_W-1:0] KC_S   = TAU_W'(K_C);
  localparam logic signed [NUM_W-1:0] TGT_FX = NUM_W'(TARGET << FRAC_W);
  localparam logic signed [NUM_W-1:0] DT_S   = NUM_W'(DT_Q);

  ode_state_e state_q, state_d;

  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STATE_W-1:0]  o_q [NCH];
  logic [STATE_W-1:0]  o_d [NCH];
  logic [NCH*IN_W-1:0] vref_q, vref_d;
  logic [NCH*IN_W-1:0] vreg_q, vreg_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic [IN_W-1:0]         vref_c, vreg_c;
  logic [STATE_W-1:0]      o_c;
  logic signed [TAU_W-1:0] tau_raw, tau;
  logic signed [NUM_W-1:0] num;
  logic signed [NUM_W:0]   sum;
  logic [STATE_W-1:0]      o_new;

  logic                    div_start, div_busy, div_done;
  logic signed [NUM_W-1:0] div_q;

`ifdef EVAL_SAT_EN
  logic sat_q, sat_d;
  logic clamp;
`else
  logic unused_sum_hi;
`endif

  always_comb begin
    vref_c  = vref_q[ch_q*IN_W +: IN_W];
    vreg_c  = vreg_q[ch_q*IN_W +: IN_W];
    o_c     = o_q[ch_q];
    tau_raw = KREF_S * signed'(TAU_W'(vref_c))
            + KREG_S * signed'(TAU_W'(vreg_c))
            + KC_S;
    // A non-positive time constant would diverge; use the fastest legal one.
    tau = (tau_raw[TAU_W-1] || tau_raw == '0) ? TAU_W'(1) : tau_raw;
    num = (TGT_FX - signed'(NUM_W'(o_c))) * DT_S;
    sum = signed'((NUM_W+1)'(o_c)) + (NUM_W+1)'(div_q);
  end

`ifdef EVAL_SAT_EN
  always_comb begin
    clamp = 1'b0;
    o_new = sum[STATE_W-1:0];
    if (sum[NUM_W]) begin
      clamp = 1'b1;
      o_new = '0;
    end else if (|sum[NUM_W-1:STATE_W]) begin
      clamp = 1'b1;
      o_new = '1;
    end
  end
`else
  assign o_new         = sum[STATE_W-1:0];
  assign unused_sum_hi = ^sum[NUM_W:STATE_W];
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    vref_d    = vref_q;
    vreg_d    = vreg_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q | (step && state_q != IDLE);
    div_start = 1'b0;
`ifdef EVAL_SAT_EN
    sat_d     = sat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (step) begin
          vref_d  = vref;
          vreg_d  = vreg;
          ch_d    = '0;
          state_d = TAU;
        end
      end
      TAU: begin
        div_start = 1'b1;
        cnt_d     = '0;
        state_d   = DIV;
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (div_busy && cnt_q == CNT_W'(NUM_W - 1)) begin
          state_d = UPD;
        end
      end
      UPD: begin
        if (div_done) begin
          o_d[ch_q] = o_new;
`ifdef EVAL_SAT_EN
          sat_d = sat_q | clamp;
`endif
        end
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = TAU;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      vref_q  <= '0;
      vreg_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        o_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      vref_q  <= vref_d;
      vreg_q  <= vreg_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      o_q     <= o_d;
    end
  end

`ifdef EVAL_SAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  eval_seq_div #(
    .NUM_W(NUM_W),
    .TAU_W(TAU_W)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (div_start),
    .num    (num),
    .den    (tau),
    .busy   (div_busy),
    .done   (div_done),
    .quo    (div_q)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign out[c*OUT_W +: OUT_W] = o_q[c][STATE_W-1:FRAC_W];
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_evaluate_ode_mc_fp.sv
// tb_evaluate_ode_mc_fp: directed and randomized checks of evaluate_ode_mc_fp
// against an arithmetic reference model; four differently configured instances.
module tb_evaluate_ode_mc_fp;

  logic clk;
  logic reset_n;
  logic [3:0] step_v;
  logic [3:0] busy_v, done_v, ovr_v, sat_v;

  logic [35:0] vref0, vreg0, vref1, vreg1;
  logic [8:0]  vref2, vreg2, vref3, vreg3;
  logic [27:0] out0, out1;
  logic [6:0]  out2, out3;

  int n_cmp = 0;
  int n_err = 0;

  longint m1 [4];
  longint sat1;
  int rv [4];
  int gv [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  evaluate_ode_mc_fp #(.NCH(4), .K_REF(0), .K_REG(0), .K_C(256)) u0 (
    .clk(clk), .reset_n(reset_n), .step(step_v[0]),
    .vref(vref0), .vreg(vreg0), .out(out0),
    .busy(busy_v[0]), .done(done_v[0]),
    .overrun(ovr_v[0]), .sat(sat_v[0])
  );

  evaluate_ode_mc_fp u1 (
    .clk(clk), .reset_n(reset_n), .step(step_v[1]),
    .vref(vref1), .vreg(vreg1), .out(out1),
    .busy(busy_v[1]), .done(done_v[1]),
    .overrun(ovr_v[1]), .sat(sat_v[1])
  );

  evaluate_ode_mc_fp #(.NCH(1), .K_REF(-1), .K_REG(1), .K_C(0)) u2 (
    .clk(clk), .reset_n(reset_n), .step(step_v[2]),
    .vref(vref2), .vreg(vreg2), .out(out2),
    .busy(busy_v[2]), .done(done_v[2]),
    .overrun(ovr_v[2]), .sat(sat_v[2])
  );

  evaluate_ode_mc_fp #(.NCH(1), .K_REF(-1), .K_REG(1), .K_C(0),
                       .TARGET(127), .DT_Q(3)) u3 (
    .clk(clk), .reset_n(reset_n), .step(step_v[3]),
    .vref(vref3), .vreg(vreg3), .out(out3),
    .busy(busy_v[3]), .done(done_v[3]),
    .overrun(ovr_v[3]), .sat(sat_v[3])
  );

  // One ODE step of one channel, straight from the defining equations.
  function automatic longint model(input longint o, input longint vr,
                                   input longint vg, input longint kr,
                                   input longint kg, input longint kc,
                                   input longint tgt, input longint dtq,
                                   output longint clamped);
    longint tau, num, q, s;
    tau = kr * vr + kg * vg + kc;
    if (tau <= 0) tau = 1;
    num = (tgt * 512 - o) * dtq;
    q = num / tau;
    s = o + q;
    clamped = 0;
`ifdef EVAL_SAT_EN
    if (s < 0) begin
      s = 0;
      clamped = 1;
    end else if (s > 65535) begin
      s = 65535;
      clamped = 1;
    end
`else
    s = s & 64'hFFFF;
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int d);
    @(negedge clk);
    step_v[d] = 1'b1;
    @(negedge clk);
    step_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (done_v[d]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out0"}, longint'(out0), 0);
    chk({tag, "_out1"}, longint'(out1), 0);
    chk({tag, "_out2"}, longint'(out2), 0);
    chk({tag, "_out3"}, longint'(out3), 0);
    chk({tag, "_busy"}, longint'(busy_v), 0);
    chk({tag, "_done"}, longint'(done_v), 0);
    chk({tag, "_ovr"}, longint'(ovr_v), 0);
    chk({tag, "_sat"}, longint'(sat_v), 0);
  endtask

  task automatic step_u1(input int scramble_at);
    int lat;
    longint cl;
    for (int c = 0; c < 4; c++) begin
      rv[c] = $urandom_range(0, 511);
      gv[c] = $urandom_range(0, 511);
      vref1[c*9 +: 9] = 9'(rv[c]);
      vreg1[c*9 +: 9] = 9'(gv[c]);
    end
    pulse(1);
    repeat (scramble_at) @(negedge clk);
    vref1 = 36'({$urandom, $urandom});
    vreg1 = 36'({$urandom, $urandom});
    wait_done(1, 200, lat);
    chk("u1_latency", longint'(lat + scramble_at), 96);
    for (int c = 0; c < 4; c++) begin
      m1[c] = model(m1[c], rv[c], gv[c], -1115, 1131, 1529, 105, 1, cl);
      if (cl != 0) sat1 = 1;
      chk("u1_out", longint'(out1[c*7 +: 7]), m1[c] >> 9);
    end
    chk("u1_sat", longint'(sat_v[1]), sat1);
  endtask

  initial begin
    int lat;
    int ndone;
    reset_n = 1'b0;
    step_v  = '0;
    vref0 = '0; vreg0 = '0; vref1 = '0; vreg1 = '0;
    vref2 = '0; vreg2 = '0; vref3 = '0; vreg3 = '0;
    for (int c = 0; c < 4; c++) m1[c] = 0;
    sat1 = 0;
    repeat (3) @(negedge clk);
    chk_zero("rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_rel");

    // Constant tau=256 on four channels: 210, then 209 more by truncation.
    vref0 = 36'({$urandom, $urandom});
    vreg0 = 36'({$urandom, $urandom});
    pulse(0);
    chk("u0_busy", longint'(busy_v[0]), 1);
    wait_done(0, 200, lat);
    chk("u0_lat1", longint'(lat), 96);
    @(negedge clk);
    chk("u0_done_pulse", longint'(done_v[0]), 0);
    chk("u0_idle", longint'(busy_v[0]), 0);
    for (int c = 0; c < 4; c++) begin
      chk("u0_o1", longint'(u0.o_q[c]), 210);
      chk("u0_out1", longint'(out0[c*7 +: 7]), 0);
    end
    pulse(0);
    wait_done(0, 200, lat);
    chk("u0_lat2", longint'(lat), 96);
    for (int c = 0; c < 4; c++) begin
      chk("u0_o2", longint'(u0.o_q[c]), 419);
    end

    // tau = -10 + 10 + 0 clamps to 1.
    vref2 = 9'd10;
    vreg2 = 9'd10;
    pulse(2);
    wait_done(2, 100, lat);
    chk("u2_lat", longint'(lat), 24);
    chk("u2_o", longint'(u2.o_q[0]), 53760);
    chk("u2_out", longint'(out2), 105);

    vref3 = 9'd10;
    vreg3 = 9'd10;
    pulse(3);
    wait_done(3, 100, lat);
    chk("u3_lat", longint'(lat), 24);
`ifdef EVAL_SAT_EN
    chk("u3_o", longint'(u3.o_q[0]), 65535);
    chk("u3_sat", longint'(sat_v[3]), 1);
    chk("u3_out", longint'(out3), 127);
`else
    chk("u3_o", longint'(u3.o_q[0]), 64000);
    chk("u3_sat", longint'(sat_v[3]), 0);
    chk("u3_out", longint'(out3), 125);
`endif

    for (int k = 0; k < 6; k++) begin
      step_u1(5 + k);
    end

    // Second request lands five cycles into the step and is dropped.
    chk("u1_ovr_pre", longint'(ovr_v[1]), 0);
    for (int c = 0; c < 4; c++) begin
      rv[c] = $urandom_range(0, 511);
      gv[c] = $urandom_range(0, 511);
      vref1[c*9 +: 9] = 9'(rv[c]);
      vreg1[c*9 +: 9] = 9'(gv[c]);
    end
    pulse(1);
    repeat (3) @(negedge clk);
    pulse(1);
    chk("u1_ovr", longint'(ovr_v[1]), 1);
    ndone = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done_v[1]) ndone++;
    end
    chk("u1_ovr_ndone", longint'(ndone), 1);
    for (int c = 0; c < 4; c++) begin
      longint cl;
      m1[c] = model(m1[c], rv[c], gv[c], -1115, 1131, 1529, 105, 1, cl);
      if (cl != 0) sat1 = 1;
      chk("u1_ovr_out", longint'(out1[c*7 +: 7]), m1[c] >> 9);
    end

    // Abort u0 in the divide of channel 2, then restart from zero.
    pulse(0);
    ndone = 0;
    for (int n = 0; n < 59; n++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("u0_abort_ndone", longint'(ndone), 0);
    chk("u0_abort_busy", longint'(busy_v[0]), 1);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    for (int c = 0; c < 4; c++) m1[c] = 0;
    sat1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_done", longint'(done_v[0]), 0);
    reset_n = 1'b1;
    pulse(0);
    wait_done(0, 200, lat);
    chk("u0_lat3", longint'(lat), 96);
    for (int c = 0; c < 4; c++) begin
      chk("u0_o3", longint'(u0.o_q[c]), 210);
    end
    step_u1(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
